parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Shares the single bidirectional barrier at the lot ramp between the entry and exit queues.
//  Grants one direction at a time and sequences the barrier open -> wait for car -> close.
//  Consumes the one-cycle car_in/car_out pulses and occupancy count from the sensor/counter block.
//  Refuses entry while the lot is at CAPACITY.
// PARAMETERS
//  CW         3   width of occupancy count
//  CAPACITY   7   max cars; entry eligible only while count < CAPACITY
//  MOVE_CYC   4   barrier travel time in cycles (opening and closing each), >=1
//  TIMEOUT    32  max cycles in WAIT_PASS before forced close, >=1
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_in       in   1   car waiting at entry side (level)
//  req_out      in   1   car waiting at exit side (level)
//  car_in       in   1   one-cycle pulse: car completed entry
//  car_out      in   1   one-cycle pulse: car completed exit
//  count        in   CW  current occupancy
//  gate_open    out  1   barrier drive: 1 = open/opening
//  grant_in     out  1   entry direction being served (OPENING..CLOSING)
//  grant_out    out  1   exit direction being served
//  full         out  1   registered (count >= CAPACITY)
//  timeout_err  out  1   one-cycle pulse on forced close
// BEHAVIOUR
//  - Reset (reset=0): immediately state=IDLE; gate_open, grant_in, grant_out, timeout_err = 0;
//    full = 0; last_served = EXIT; counters = 0. Applies mid-operation too (barrier closes).
//  - All outputs registered. FSM: IDLE -> OPENING -> WAIT_PASS -> CLOSING -> IDLE.
//  - IDLE: elig_in = req_in & (count < CAPACITY); elig_out = req_out.
//    Only elig_in -> serve IN; only elig_out -> serve OUT; both -> serve opposite of last_served.
//    Grant decision made at edge where IDLE samples eligibility; grant_x and gate_open = 1 from that edge.
//    last_served updated at the grant edge.
//  - OPENING: exactly MOVE_CYC cycles, then WAIT_PASS. Timer resets on entry.
//  - WAIT_PASS: exit on matching pass pulse (car_in for IN, car_out for OUT) -> CLOSING.
//    A matching pulse during OPENING is latched and ends WAIT_PASS on its first cycle.
//    Non-matching pulses ignored. After TIMEOUT cycles without match: timeout_err = 1 for one
//    cycle, -> CLOSING. Match and timeout on the same cycle: match wins, no timeout_err.
//  - CLOSING: gate_open = 0 at entry edge; grant held; exactly MOVE_CYC cycles, then IDLE
//    with grant dropped. At least one IDLE cycle between consecutive services.
//  - Request drop or count reaching CAPACITY mid-service does not abort the service.
//  - count compared unsigned, CW bits; CAPACITY > 2^CW-1 means never full.
// CONFIGURATION
//  ARB_EXIT_PRIORITY_EN defined: on simultaneous eligibility, exit always wins (frees space);
//    last_served still tracked but unused.
//  Not defined: round-robin via last_served as above.
// TESTING
//  1. Reset low mid-WAIT_PASS -> gate_open, grants 0 same cycle; after release, IDLE, no grant w/o req.
//  2. req_in=1, count=2 -> grant_in, gate_open 1; after 4 cyc pulse car_in -> gate_open 0, IDLE 4 cyc later.
//  3. req_in=1, count=7 (full=1), req_out=0 -> no grant ever; raise req_out -> grant_out.
//  4. req_in=req_out=1 from reset, count=3 -> IN, then OUT, then IN (round-robin);
//     with ARB_EXIT_PRIORITY_EN -> OUT, OUT, OUT.
//  5. Grant OUT, no car_out for 32 cyc in WAIT_PASS -> timeout_err one pulse, close, return IDLE.
//  6. Grant IN, car_in in OPENING, stray car_out in WAIT_PASS -> car_in latched,
//     CLOSING on first WAIT_PASS cycle, car_out ignored.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Ramp barrier arbiter: serves entry/exit queues one at a time, sequencing open -> wait for car -> close.
// Optional build macro ARB_EXIT_PRIORITY_EN: exit wins simultaneous requests instead of round-robin.
module parking_gate_arbiter #(
  parameter int CW       = 3,
  parameter int CAPACITY = 7,
  parameter int MOVE_CYC = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_in,
  input  logic          req_out,
  input  logic          car_in,
  input  logic          car_out,
  input  logic [CW-1:0] count,
  output logic          gate_open,
  output logic          grant_in,
  output logic          grant_out,
  output logic          full,
  output logic          timeout_err
);

  localparam int TMAX = (MOVE_CYC > TIMEOUT) ? MOVE_CYC : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYC - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0]   CAP32     = 32'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPENING   = 2'd1,
    WAIT_PASS = 2'd2,
    CLOSING   = 2'd3
  } state_t;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_t;

  state_t        state, state_nxt;
  dir_t          last_served, last_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          pass_seen, pass_seen_nxt;
  logic          gate_nxt, gin_nxt, gout_nxt, terr_nxt, full_nxt;

  logic [31:0]   count_ext;
  logic          elig_in, elig_out, pick_out, match;

  // Widen count so a CAPACITY beyond the count range simply never reads as full.
  assign count_ext = 32'(count);
  assign elig_in   = req_in & (count_ext < CAP32);
  assign elig_out  = req_out;
  assign full_nxt  = (count_ext >= CAP32);
  assign match     = grant_in ? car_in : car_out;

`ifdef ARB_EXIT_PRIORITY_EN
  assign pick_out = elig_out;
`else
  assign pick_out = elig_out & (~elig_in | (last_served == DIR_IN));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= DIR_OUT;
      timer       <= '0;
      pass_seen   <= 1'b0;
      gate_open   <= 1'b0;
      grant_in    <= 1'b0;
      grant_out   <= 1'b0;
      full        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      timer       <= timer_nxt;
      pass_seen   <= pass_seen_nxt;
      gate_open   <= gate_nxt;
      grant_in    <= gin_nxt;
      grant_out   <= gout_nxt;
      full        <= full_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_nxt      = last_served;
    timer_nxt     = timer;
    pass_seen_nxt = pass_seen;
    gate_nxt      = gate_open;
    gin_nxt       = grant_in;
    gout_nxt      = grant_out;
    terr_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (elig_in | elig_out) begin
          state_nxt     = OPENING;
          timer_nxt     = '0;
          pass_seen_nxt = 1'b0;
          gate_nxt      = 1'b1;
          gin_nxt       = ~pick_out;
          gout_nxt      = pick_out;
          last_nxt      = pick_out ? DIR_OUT : DIR_IN;
        end
      end

      // A car that slips through while the arm is still rising is remembered here.
      OPENING: begin
        if (match) pass_seen_nxt = 1'b1;
        if (timer == MOVE_LAST) begin
          state_nxt = WAIT_PASS;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      WAIT_PASS: begin
        if (match | pass_seen) begin
          state_nxt     = CLOSING;
          timer_nxt     = '0;
          gate_nxt      = 1'b0;
          pass_seen_nxt = 1'b0;
        end else if (timer == WAIT_LAST) begin
          state_nxt = CLOSING;
          timer_nxt = '0;
          gate_nxt  = 1'b0;
          terr_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      CLOSING: begin
        if (timer == MOVE_LAST) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          gin_nxt   = 1'b0;
          gout_nxt  = 1'b0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        gate_nxt  = 1'b0;
        gin_nxt   = 1'b0;
        gout_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: cycle table plus directed multi-cycle sequences.
// Honours ARB_EXIT_PRIORITY_EN for the arbitration-order expectations.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_in, req_out, car_in, car_out;
  logic [2:0] count;
  logic       gate_open, grant_in, grant_out, full, timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .CW(3), .CAPACITY(7), .MOVE_CYC(4), .TIMEOUT(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_in(req_in),
    .req_out(req_out),
    .car_in(car_in),
    .car_out(car_out),
    .count(count),
    .gate_open(gate_open),
    .grant_in(grant_in),
    .grant_out(grant_out),
    .full(full),
    .timeout_err(timeout_err)
  );

  // Expected outputs packed as {gate_open, grant_in, grant_out, full, timeout_err}.
  typedef struct {
    logic       ri, ro, ci, co;
    logic [2:0] cnt;
    logic [4:0] exp;
    string      tag;
  } vec_t;

  vec_t vq[$];

  function automatic logic [4:0] outs();
    return {gate_open, grant_in, grant_out, full, timeout_err};
  endfunction

  task automatic check_output(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic ri, input logic ro, input logic ci,
                                input logic co, input logic [2:0] cnt);
    req_in  = ri;
    req_out = ro;
    car_in  = ci;
    car_out = co;
    count   = cnt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic ri, input logic ro, input logic ci, input logic co,
                         input logic [2:0] cnt, input logic [4:0] exp, input string tag);
    vec_t v;
    v.ri = ri; v.ro = ro; v.ci = ci; v.co = co; v.cnt = cnt; v.exp = exp; v.tag = tag;
    vq.push_back(v);
  endtask

  // One full service with both queues requesting; checks which side was granted.
  task automatic run_service(input logic exp_out, input string name);
    int n;
    n = 0;
    while (!(grant_in | grant_out) && n < 20) begin
      step();
      n++;
    end
    check_output({name, "_grant"}, {2'b00, gate_open, grant_in, grant_out},
                 exp_out ? 5'b00101 : 5'b00110);
    repeat (4) step();
    if (exp_out) car_out = 1'b1;
    else         car_in  = 1'b1;
    step();
    car_in  = 1'b0;
    car_out = 1'b0;
    n = 0;
    while ((grant_in | grant_out) && n < 20) begin
      step();
      n++;
    end
    check_output({name, "_release"}, {3'b000, grant_in, grant_out}, 5'b00000);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic bad;

    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 3'd0);
    #12;
    check_output("reset_state", outs(), 5'b00000);
    reset = 1'b1;
    step();
    check_output("idle_after_reset", outs(), 5'b00000);

    // Entry service with count dipping to capacity mid-service, then full blocks entry.
    add_vec(1, 0, 0, 0, 3'd2, 5'b11000, "t2_grant_in");
    add_vec(0, 0, 0, 0, 3'd2, 5'b11000, "t2_open1");
    add_vec(0, 0, 0, 0, 3'd7, 5'b11010, "t2_open2_full");
    add_vec(0, 0, 0, 0, 3'd7, 5'b11010, "t2_open3_full");
    add_vec(0, 0, 0, 0, 3'd2, 5'b11000, "t2_open4");
    add_vec(0, 0, 1, 0, 3'd2, 5'b01000, "t2_pass_close");
    add_vec(0, 0, 0, 0, 3'd2, 5'b01000, "t2_close1");
    add_vec(0, 0, 0, 0, 3'd2, 5'b01000, "t2_close2");
    add_vec(0, 0, 0, 0, 3'd2, 5'b01000, "t2_close3");
    add_vec(0, 0, 0, 0, 3'd2, 5'b00000, "t2_idle");
    add_vec(0, 0, 0, 0, 3'd2, 5'b00000, "t2_idle_hold");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00010, "t3_full_block1");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00010, "t3_full_block2");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00010, "t3_full_block3");
    add_vec(1, 1, 0, 0, 3'd7, 5'b10110, "t3_grant_out");
    add_vec(1, 0, 0, 0, 3'd7, 5'b10110, "t3_open1");
    add_vec(1, 0, 0, 0, 3'd7, 5'b10110, "t3_open2");
    add_vec(1, 0, 0, 0, 3'd7, 5'b10110, "t3_open3");
    add_vec(1, 0, 0, 0, 3'd7, 5'b10110, "t3_open4");
    add_vec(1, 0, 1, 0, 3'd7, 5'b10110, "t3_stray_car_in");
    add_vec(1, 0, 0, 1, 3'd7, 5'b00110, "t3_pass_close");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00110, "t3_close1");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00110, "t3_close2");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00110, "t3_close3");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00010, "t3_idle");
    add_vec(1, 0, 0, 0, 3'd7, 5'b00010, "t3_still_blocked");
    add_vec(0, 0, 0, 0, 3'd0, 5'b00000, "t3_empty");

    foreach (vq[i]) begin
      apply_stimulus(vq[i].ri, vq[i].ro, vq[i].ci, vq[i].co, vq[i].cnt);
      step();
      check_output(vq[i].tag, outs(), vq[i].exp);
    end
    apply_stimulus(0, 0, 0, 0, 3'd0);

    // Exit service times out; a stray car_in along the way must not end it.
    req_out = 1'b1;
    step();
    check_output("t5_grant_out", outs(), 5'b10100);
    req_out = 1'b0;
    repeat (4) step();
    bad = 1'b0;
    for (int i = 0; i < 31; i++) begin
      car_in = (i == 5);
      step();
      if (timeout_err !== 1'b0 || gate_open !== 1'b1) bad = 1'b1;
    end
    car_in = 1'b0;
    check_output("t5_no_early_timeout", {4'b0000, bad}, 5'b00000);
    step();
    check_output("t5_timeout_pulse", outs(), 5'b00101);
    step();
    check_output("t5_pulse_one_cycle", outs(), 5'b00100);
    repeat (2) step();
    step();
    check_output("t5_back_idle", outs(), 5'b00000);

    // Match arriving on the final WAIT_PASS cycle beats the timeout.
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    repeat (4) step();
    repeat (31) step();
    car_in = 1'b1;
    step();
    car_in = 1'b0;
    check_output("match_beats_timeout", outs(), 5'b01000);
    repeat (4) step();
    check_output("match_beats_idle", outs(), 5'b00000);

    // car_in during OPENING is latched; stray car_out in WAIT_PASS is irrelevant.
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    step();
    car_in = 1'b1;
    step();
    car_in = 1'b0;
    step();
    step();
    car_out = 1'b1;
    step();
    car_out = 1'b0;
    check_output("t6_latched_close", outs(), 5'b01000);
    repeat (4) step();
    check_output("t6_idle", outs(), 5'b00000);

    // Asynchronous reset while waiting for a car.
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    repeat (4) step();
    check_output("t1_in_wait", outs(), 5'b11000);
    #2;
    reset = 1'b0;
    #1;
    check_output("t1_async_reset", outs(), 5'b00000);
    #2;
    reset = 1'b1;
    repeat (3) step();
    check_output("t1_idle_no_req", outs(), 5'b00000);

    // Both sides requesting straight from reset.
    apply_stimulus(1, 1, 0, 0, 3'd3);
`ifdef ARB_EXIT_PRIORITY_EN
    run_service(1'b1, "t4_first");
    run_service(1'b1, "t4_second");
    run_service(1'b1, "t4_third");
`else
    run_service(1'b0, "t4_first");
    run_service(1'b1, "t4_second");
    run_service(1'b0, "t4_third");
`endif
    apply_stimulus(0, 0, 0, 0, 3'd3);
    step();
    step();
    check_output("t4_quiet", outs(), 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
